// File: rtl/countdown_modulo_n.sv
// Programmable modulo-N down counter / timer with one-shot and auto-reload modes.
// Terminal count is flagged by a registered one-cycle tc pulse.
module countdown_modulo_n #(
    parameter int N         = 10,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 periodic,
    input  logic                 enable,
    input  logic                 abort,
    output logic [CNT_WIDTH-1:0] counter_out,
    output logic                 tc,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL = CNT_WIDTH'(N - 1);
    localparam logic [CNT_WIDTH-1:0] ZERO    = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [CNT_WIDTH-1:0]   reload_val_r;
    logic                   mode_r;
    logic [CNT_WIDTH-1:0]   start_val_s;

    // Zero and out-of-range requests both select the full modulus.
    function automatic logic [CNT_WIDTH-1:0] effective_load(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if ((value == ZERO) || (value > MAX_VAL)) begin
            result = MAX_VAL;
        end else begin
            result = value;
        end
        return result;
    endfunction

    assign start_val_s = effective_load(load_value);

    // Control FSM and all registered outputs; priority abort > start > enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            counter_out  <= ZERO;
            tc           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            reload_val_r <= ZERO;
            mode_r       <= 1'b0;
        end else if (abort) begin
            state_r     <= IDLE;
            counter_out <= ZERO;
            tc          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (start) begin
            // Accepting start is not a tick, and a restart never raises tc.
            state_r      <= RUN;
            counter_out  <= start_val_s;
            reload_val_r <= start_val_s;
            mode_r       <= periodic;
            tc           <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    counter_out <= ZERO;
                    tc          <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
                RUN: begin
                    if (!enable) begin
                        tc <= 1'b0;
                    end else if (counter_out != ZERO) begin
                        counter_out <= counter_out - ONE;
                        tc          <= 1'b0;
                    end else if (mode_r) begin
                        counter_out <= reload_val_r;
                        tc          <= 1'b1;
                    end else begin
                        state_r <= DONE;
                        tc      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    counter_out <= ZERO;
                    tc          <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    counter_out <= ZERO;
                    tc          <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/countdown_modulo_n.md
# countdown_modulo_n

Programmable modulo-N down counter and timer: the counting-down counterpart of the team's modulo-N up counter. It loads a start value, then decrements once per enabled tick to 0. At 0 it either reloads (periodic mode) or stops (one-shot mode), and it flags each terminal count with a registered one-cycle pulse. It sits beside the up counter in the timing and prescaler logic, and provides programmable-period tick generation and timeouts.

## Interface
- N, 10: maximum modulus; the counter value never exceeds N-1.
- CNT_WIDTH, 4: counter width; must satisfy 2^CNT_WIDTH >= N.

- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request: load a value and begin counting.
- load_value  in  CNT_WIDTH  start value, sampled only when start is accepted.
- periodic  in  1  mode, sampled with start: 1 = auto-reload, 0 = one-shot.
- enable  in  1  count tick qualifier; one decrement per cycle while high in RUN.
- abort  in  1  stop immediately and return to IDLE.
- counter_out  out  CNT_WIDTH  current count (registered).
- tc  out  1  terminal-count pulse, one cycle wide (registered).
- busy  out  1  high in RUN.
- done  out  1  high in DONE; one-shot run has completed.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - reload_val (CNT_WIDTH), the latched start value.
  - mode_q, the latched periodic bit.
- Effective load value:
  - load_value == 0 → N-1.
  - load_value > N-1 → N-1.
  - otherwise → load_value.
- Start value V gives a period of V+1 enabled ticks. Default behaviour is modulo-N.
- IDLE:
  - counter_out = 0, busy = 0, done = 0.
  - start → counter_out <= effective load value; reload_val and mode_q latched; go to RUN.
- RUN, enabled tick with counter_out != 0: counter_out <= counter_out - 1.
- RUN, enabled tick with counter_out == 0:
  - tc <= 1 on the next cycle.
  - mode_q = 1 → counter_out <= reload_val; stay in RUN.
  - mode_q = 0 → counter_out stays 0; go to DONE.
- RUN, enable low: hold all state.
- RUN, start: restart. Reload from the new load_value and periodic, with no tc.
- DONE:
  - done = 1, busy = 0, counter_out = 0.
  - start → load and go to RUN, as from IDLE.
- abort in any state: next cycle is IDLE with counter_out = 0. No tc is generated, and a pending terminal tick is discarded.
- Priority, highest first: reset_n, abort, start, enable.
- enable is ignored outside RUN, and ignored in the cycle start is accepted (that cycle does not count as a tick).
- Decrement never underflows. The zero check precedes the decrement, so counter_out stays within 0..N-1 at all times.

## Timing
- Reset: asynchronous assertion and clean release. Reset values:
  - state = IDLE
  - counter_out = 0
  - tc = 0
  - busy = 0
  - done = 0
  - reload_val = 0
  - mode_q = 0
- Reset mid-count aborts immediately; no tc is produced.
- start at edge k: counter_out = V and busy = 1 after edge k.
- With continuous enable from edge k+1:
  - counter_out reaches 0 after edge k+V.
  - tc = 1 after edge k+V+1, for exactly one cycle.
  - In periodic mode, counter_out = V again after that same edge k+V+1.
- Periodic with continuous enable: tc high one cycle in every V+1. With V = 0 (after clamp, i.e. N = 1), tc is high on every enabled tick.
- One-shot: done and tc rise in the same cycle; busy falls in that cycle.
- Gaps in enable stretch the timing exactly by the number of low cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset during RUN at counter_out = 5 → all outputs 0 immediately (asynchronous); IDLE after release; no tc.
- N = 10, start with load_value = 3, periodic = 0, enable held high → counter_out goes 3, 2, 1, 0; tc pulses once, 4 ticks after load; done = 1; counter_out stays 0.
- periodic = 1, load_value = 0 (maps to 9), enable held high for 30 cycles → tc exactly 3 times, spaced 10 cycles apart; counter_out wraps 0 → 9.
- load_value = 12 with N = 10 → loads 9; enable toggled 1010… → tc after 20 cycles.
- Mid-run start with load_value = 2 while counter_out = 6 → reloads to 2 with no tc; abort asserted together with start → IDLE, counter_out = 0.
- Terminal tick and abort in the same cycle → no tc, IDLE; then start from DONE → RUN, done drops on the next cycle.
